// File: rtl/multiplier_radix4_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier: state encoding,
// sizing constants and the Booth digit-to-addend selection.
package multiplier_radix4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

    localparam int MUL_STEPS = 32;
    localparam int MUL_W     = 64;

    // Addend is two bits wider than M so that +/-2M cannot overflow.
    function automatic logic [MUL_W+1:0] booth_addend(input logic [2:0]       window,
                                                      input logic [MUL_W-1:0] m);
        logic [MUL_W+1:0] m_ext;
        m_ext = {{2{m[MUL_W-1]}}, m};
        case (window)
            3'b001, 3'b010: booth_addend = m_ext;
            3'b011:         booth_addend = {m_ext[MUL_W:0], 1'b0};
            3'b100:         booth_addend = -{m_ext[MUL_W:0], 1'b0};
            3'b101, 3'b110: booth_addend = -m_ext;
            default:        booth_addend = {(MUL_W+2){1'b0}};
        endcase
    endfunction

endpackage

// File: rtl/multiplier_radix4_cal_radix4.sv
// One combinational radix-4 Booth step: add the selected multiple of M into the
// upper half of the partial product, then shift the whole value right by two.
module cal_radix4
    import multiplier_radix4_pkg::*;
(
    input  logic [MUL_W-1:0]   multiplier,
    input  logic [2:0]         last_3bits,
    input  logic [2*MUL_W-1:0] result_in,
    output logic [2*MUL_W-1:0] result_out
);

    localparam int PW = 2 * MUL_W;

    logic [MUL_W+1:0]       addend_s;
    logic signed [PW+1:0]   sum_s;

    // Sum is carried at PW+2 bits so the intermediate before the shift is exact.
    always_comb begin
        addend_s   = booth_addend(last_3bits, multiplier);
        sum_s      = $signed({{2{result_in[PW-1]}}, result_in})
                   + $signed({addend_s, {MUL_W{1'b0}}});
        result_out = PW'(sum_s >>> 2);
    end

endmodule

// File: rtl/multiplier_radix4.sv
// Sequential 64x64 signed multiplier: FSM, step counter and partial-product
// register around a single combinational radix-4 Booth step.
module multiplier_radix4
    import multiplier_radix4_pkg::*;
#(
    parameter int WIDTH = MUL_W,
    parameter int STEPS = MUL_STEPS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    mul_state_e           state_r;
    mul_state_e           next_state_s;
    logic [WIDTH-1:0]     m_reg_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic                 q_m1_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 op_done_r;
    logic [2*WIDTH-1:0]   step_out_s;
    logic                 load_s;
    logic                 step_s;
    logic                 done_d_s;

    cal_radix4 u_step (
        .multiplier (m_reg_r),
        .last_3bits ({acc_r[1], acc_r[0], q_m1_r}),
        .result_in  (acc_r),
        .result_out (step_out_s)
    );

    // State register; op_clear forces IDLE regardless of state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else if (op_clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (op_start) next_state_s = ST_EXEC;
                else          next_state_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (cnt_r == LAST_CNT) next_state_s = ST_DONE;
                else                   next_state_s = ST_EXEC;
            end
            ST_DONE: begin
                if (op_start) next_state_s = ST_EXEC;
                else          next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath controls; done_d_s is the value op_done takes on the next edge.
    always_comb begin
        load_s   = 1'b0;
        step_s   = 1'b0;
        done_d_s = 1'b0;
        case (state_r)
            ST_IDLE: load_s = op_start;
            ST_EXEC: begin
                step_s   = 1'b1;
                done_d_s = (cnt_r == LAST_CNT);
            end
            ST_DONE: begin
                load_s   = op_start;
                done_d_s = ~op_start;
            end
            default: begin
                load_s   = 1'b0;
                step_s   = 1'b0;
                done_d_s = 1'b0;
            end
        endcase
    end

    // Operand capture, Booth iteration and registered done flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg_r   <= '0;
            acc_r     <= '0;
            q_m1_r    <= 1'b0;
            cnt_r     <= '0;
            op_done_r <= 1'b0;
        end else if (op_clear) begin
            acc_r     <= '0;
            q_m1_r    <= 1'b0;
            cnt_r     <= '0;
            op_done_r <= 1'b0;
        end else if (load_s) begin
            m_reg_r   <= multiplier;
            acc_r     <= {{WIDTH{1'b0}}, multiplicand};
            q_m1_r    <= 1'b0;
            cnt_r     <= '0;
            op_done_r <= 1'b0;
        end else if (step_s) begin
            acc_r     <= step_out_s;
            q_m1_r    <= acc_r[1];
            cnt_r     <= cnt_r + CNT_W'(1);
            op_done_r <= done_d_s;
        end else begin
            op_done_r <= done_d_s;
        end
    end

    assign op_done = op_done_r;
    assign result  = acc_r;

endmodule
